hangman_engine_param: RTL

- Parametrised next-generation hangman core. Replaces the fixed 5-letter / 7-try / 32-symbol game controller and datapath.
- Word length, symbol width, try budget and word-table depth are parameters.
- All occurrences of a guessed letter are revealed in one guess. `next` is edge-detected rather than level-sensitive. All game state is held in real registers; there are no combinational latches.
- Sits between the pad-level input bus and an external word ROM. Drives the guessed-letter mask, win/lose and remaining-tries outputs to the pads.

---
 rtl/hangman_engine_param_if.sv | 33 +++
 rtl/hangman_engine_param.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hangman_engine_param_if.sv
// hangman_engine_param_if: player, word-ROM and pad-output bus of the hangman engine.
// The dup pulse exists only when HANGMAN_GUESS_HISTORY_EN is defined.
interface hangman_engine_param_if #(
  parameter int WORD_LEN = 5,
  parameter int CHAR_W = 5,
  parameter int ADDR_W = 6,
  parameter int TRY_W = 3
);
  logic next;
  logic [CHAR_W-1:0] guess_char;
  logic [ADDR_W-1:0] word_sel;
  logic [ADDR_W-1:0] word_addr;
  logic [WORD_LEN*CHAR_W-1:0] word_data;
  logic [WORD_LEN-1:0] guessed;
  logic [TRY_W-1:0] tries_left;
  logic hit;
  logic miss;
  logic busy;
  logic win;
  logic lose;
`ifdef HANGMAN_GUESS_HISTORY_EN
  logic dup;
  modport master (output next, guess_char, word_sel, word_data,
                  input word_addr, guessed, tries_left, hit, miss, busy, win, lose, dup);
  modport slave (input next, guess_char, word_sel, word_data,
                 output word_addr, guessed, tries_left, hit, miss, busy, win, lose, dup);
`else
  modport master (output next, guess_char, word_sel, word_data,
                  input word_addr, guessed, tries_left, hit, miss, busy, win, lose);
  modport slave (input next, guess_char, word_sel, word_data,
                 output word_addr, guessed, tries_left, hit, miss, busy, win, lose);
`endif
endinterface

// File: rtl/hangman_engine_param.sv
// hangman_engine_param: parametrised hangman game core with edge-detected strobe.
// Define HANGMAN_GUESS_HISTORY_EN to ignore repeated letters and pulse dup instead.
module hangman_engine_param #(
  parameter int WORD_LEN = 5,
  parameter int CHAR_W = 5,
  parameter int MAX_TRIES = 7,
  parameter int ADDR_W = 6,
  parameter int TRY_W = $clog2(MAX_TRIES + 1)
) (
  input logic clk,
  input logic reset,
  hangman_engine_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, GUESS, CHECK, RESOLVE, WIN, LOSE} state_t;
  state_t state_q, state_d;
  logic nxt_q;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [WORD_LEN*CHAR_W-1:0] word_q, word_d;
  logic [CHAR_W-1:0] guess_q, guess_d;
  logic [WORD_LEN-1:0] guessed_q, guessed_d, match;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic hit_q, hit_d, miss_q, miss_d, win_q, win_d, lose_q, lose_d;
  logic ev, fresh;
  assign ev = bus.next & ~nxt_q;
  for (genvar i = 0; i < WORD_LEN; i++) begin : g_match
    assign match[i] = word_q[i*CHAR_W +: CHAR_W] == guess_q;
  end
`ifdef HANGMAN_GUESS_HISTORY_EN
  logic [2**CHAR_W-1:0] used_q, used_d;
  logic dup_q, dup_d;
  assign fresh = ~used_q[guess_q];
  always_comb begin
    used_d = used_q;
    if (state_q == CHECK) used_d[guess_q] = 1'b1;
    if (state_q == IDLE) used_d = '0;
    dup_d = state_q == CHECK && !fresh;
  end
  always_ff @(posedge clk) begin
    used_q <= reset ? used_d : '0;
    dup_q <= reset ? dup_d : 1'b0;
  end
  assign bus.dup = dup_q;
`else
  assign fresh = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      nxt_q <= 1'b1;
      word_addr_q <= '0;
      word_q <= '0;
      guess_q <= '0;
      guessed_q <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q <= bus.next;
      word_addr_q <= word_addr_d;
      word_q <= word_d;
      guess_q <= guess_d;
      guessed_q <= guessed_d;
      tries_q <= tries_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      win_q <= win_d;
      lose_q <= lose_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = ev ? LOAD0 : IDLE;
      LOAD0: state_d = LOAD1;
      LOAD1: state_d = GUESS;
      GUESS: state_d = ev ? CHECK : GUESS;
      CHECK: state_d = RESOLVE;
      RESOLVE: state_d = &guessed_q ? WIN : tries_q == '0 ? LOSE : GUESS;
      WIN: state_d = ev ? IDLE : WIN;
      LOSE: state_d = ev ? IDLE : LOSE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    word_addr_d = word_addr_q;
    word_d = word_q;
    guess_d = guess_q;
    guessed_d = guessed_q;
    tries_d = tries_q;
    hit_d = 1'b0;
    miss_d = 1'b0;
    win_d = win_q;
    lose_d = lose_q;
    case (state_q)
      IDLE: word_addr_d = ev ? bus.word_sel : word_addr_q;
      LOAD1: word_d = bus.word_data;
      GUESS: guess_d = ev ? bus.guess_char : guess_q;
      CHECK: if (fresh) begin
        guessed_d = guessed_q | match;
        hit_d = |match;
        miss_d = ~|match;
        tries_d = (|match || tries_q == '0) ? tries_q : tries_q - TRY_W'(1);
      end
      RESOLVE: begin
        win_d = &guessed_q;
        lose_d = ~&guessed_q && tries_q == '0;
      end
      WIN, LOSE: if (ev) begin
        guessed_d = '0;
        tries_d = TRY_W'(MAX_TRIES);
        win_d = 1'b0;
        lose_d = 1'b0;
      end
      default: ;
    endcase
  end
  assign bus.word_addr = word_addr_q;
  assign bus.guessed = guessed_q;
  assign bus.tries_left = tries_q;
  assign bus.hit = hit_q;
  assign bus.miss = miss_q;
  assign bus.win = win_q;
  assign bus.lose = lose_q;
  assign bus.busy = state_q inside {LOAD0, LOAD1, CHECK, RESOLVE};
endmodule
